// File: rtl/word_serializer_4_pkg.sv
// Shared types and constants for the four-word batch serializer.
package word_serializer_4_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [1:0] BEAT_A = 2'd0;
    localparam logic [1:0] BEAT_B = 2'd1;
    localparam logic [1:0] BEAT_C = 2'd2;
    localparam logic [1:0] BEAT_D = 2'd3;

endpackage

// File: rtl/mux_4to1.sv
// Generic 4-input word multiplexer selected by a 2-bit index.
module mux_4to1
    import word_serializer_4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = in0;
        case (sel)
            BEAT_A: y = in0;
            BEAT_B: y = in1;
            BEAT_C: y = in2;
            BEAT_D: y = in3;
            default: y = in0;
        endcase
    end

endmodule

// File: rtl/word_serializer_4.sv
// Captures a batch of four words and emits them one beat per handshake,
// a first, d last, with zero-bubble reload on the final beat.
module word_serializer_4
    import word_serializer_4_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             s0,
    output logic             s1,
    output logic             out_last
);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       idx;
    logic [WIDTH-1:0] wa, wb, wc, wd;
    logic             last_xfer;
    logic             accept;

    assign last_xfer = (state == SEND) && out_ready && (idx == BEAT_D);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = SEND;
            end
            SEND: begin
                if (last_xfer) state_nxt = in_valid ? SEND : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready is the only output with a path from an input (out_ready).
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = (idx == BEAT_D);
                in_ready  = last_xfer;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Index wraps 11 -> 00 naturally; a reload on the last beat also forces 00.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= BEAT_A;
            wa  <= '0;
            wb  <= '0;
            wc  <= '0;
            wd  <= '0;
        end else if (accept) begin
            idx <= BEAT_A;
            wa  <= a;
            wb  <= b;
            wc  <= c;
            wd  <= d;
        end else if ((state == SEND) && out_ready) begin
            idx <= idx + 2'd1;
        end
    end

    mux_4to1 #(.WIDTH(WIDTH)) u_mux (
        .in0 (wa),
        .in1 (wb),
        .in2 (wc),
        .in3 (wd),
        .sel (idx),
        .y   (Y)
    );

    assign s0 = idx[0];
    assign s1 = idx[1];

endmodule

// File: doc/word_serializer_4.md
WORD_SERIALIZER_4 -- requirements
Module: word_serializer_4

Interface
REQ-001 Parameter WIDTH, default 32, sets the width of every data word.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low; one clock, reset is synchronous and active-low.
REQ-004 in_valid  input  1  upstream offers a batch of four words.
REQ-005 in_ready  output  1  block accepts the batch this cycle.
REQ-006 a, b, c, d  input  WIDTH each  batch words, beat order a, b, c, d.
REQ-007 out_valid  output  1  Y holds a valid beat.
REQ-008 out_ready  input  1  downstream consumes the beat this cycle.
REQ-009 Y  output  WIDTH  current beat word.
REQ-010 s0, s1  output  1 each  current beat index, {s1,s0}: 00=a, 01=b, 10=c, 11=d.
REQ-011 out_last  output  1  current beat is word d.

Function
REQ-012 The block SHALL implement two states: IDLE and SEND.
REQ-013 In IDLE: in_ready=1, out_valid=0, out_last=0, {s1,s0}=00.
REQ-014 When in_valid & in_ready, the block SHALL capture a..d into internal registers, set the beat index to 00 and enter SEND on the next cycle.
REQ-015 In SEND: out_valid=1; Y SHALL equal the captured word selected by {s1,s0}; out_last=1 only when index=11.
REQ-016 A beat transfers when out_valid & out_ready; the index SHALL then increment by 1.
REQ-017 While out_ready=0 in SEND, Y, s0, s1 and out_last SHALL hold.
REQ-018 On transfer of beat 11, the index SHALL wrap to 00.
REQ-019 In SEND, in_ready SHALL be 1 only when index=11 and out_ready=1.
REQ-020 Last-beat transfer with in_valid=1: the new batch SHALL be captured and SEND entered at beat 00 with no idle cycle, giving sustained 1 beat/cycle.
REQ-021 Last-beat transfer with in_valid=0: the block SHALL return to IDLE.
REQ-022 Input words SHALL be ignored unless captured; changes to a..d during SEND SHALL NOT affect Y.
REQ-023 Latency: beat a SHALL appear on Y the cycle after input acceptance.
REQ-024 Y SHALL be driven from registered state only; in_ready is the only output with a combinational path from an input (out_ready).

Reset
REQ-025 While rst_n=0 at a clock edge: state=IDLE, index=00, captured words=0.
REQ-026 Reset asserted mid-batch SHALL discard remaining beats; no beat is emitted after reset release until a new batch is accepted.
REQ-027 After reset: out_valid=0, in_ready=1, Y=0, s0=s1=0, out_last=0.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, SEND) and the beat-index constants for a, b, c and d.
REQ-029 Beat selection SHALL instantiate the team's existing mux_4to1 as the single sub-module, driven by the captured words and the index bits.
REQ-030 Target size: 120-250 lines of RTL.

Verification
REQ-031 Single batch: a=1, b=2, c=3, d=4, out_ready=1 -> Y=1,2,3,4 on consecutive cycles; out_last only with 4; then IDLE.
REQ-032 Backpressure: out_ready=0 for 3 cycles during beat 10 with c=3458578 -> Y holds 3458578, {s1,s0}=10 held; then resumes with d.
REQ-033 Back-to-back: two batches (1..4 and 16778, 5, 6, 7) with in_valid held -> 8 consecutive beats, no bubble; in_ready=1 exactly on the beat-4 cycle.
REQ-034 Reset mid-batch: rst_n=0 after beat b -> next cycle out_valid=0, Y=0, in_ready=1; c and d are never emitted.
REQ-035 Input isolation: change a..d to all-ones during SEND -> emitted beats equal the originally captured values.
REQ-036 Idle: in_valid=0 for 10 cycles -> out_valid stays 0, in_ready stays 1.
